uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Transmit-side byte buffer for the serial peripherals: an upstream producer writes bytes at any rate up to one per clock, and the block feeds them one at a time to a `uart_tx` unit through its `data`/`start`/`ready` handshake. It replaces the constant-`start` driving used in simple demos, so firmware-like logic can queue whole messages without watching the transmitter. It sits directly upstream of `uart_tx`, with `data`→`data`, `start`→`start` and `ready`←`ready`.

## Interface
- `DEPTH`, 16: number of byte entries. Must be a power of two, ≥ 2.
- `AW`, `$clog2(DEPTH)`: pointer width. Derived; not to be overridden.
- `clk` input 1: system clock. All logic is rising-edge.
- `rstn` input 1: asynchronous, active-low reset.
- `din` input 8: write data.
- `wr` input 1: write strobe. One byte is accepted per cycle when high and not full.
- `full` output 1: high when `count == DEPTH`.
- `empty` output 1: high when `count == 0`.
- `count` output AW+1: number of stored bytes, from 0 to DEPTH.
- `overflow` output 1: one-cycle pulse when `wr` is high while `full` is high.
- `data` output 8: byte presented to `uart_tx`.
- `start` output 1: request to `uart_tx`.
- `ready` input 1: from `uart_tx`. High when it is idle and able to accept a byte.

## Operation
- Storage is a circular buffer of DEPTH×8 bits.
  - Write pointer and read pointer are AW bits each and wrap modulo DEPTH.
  - `count` is a separate register.
- Write behaviour:
  - When `wr` is high and `full` is low, `din` is stored at the write pointer and the write pointer increments.
  - When `wr` is high and `full` is high, the byte is dropped, the pointers are unchanged, and `overflow` is high for the next cycle.
  - A pop occurring in the same cycle does not make room for that write.
- Pop: reading an entry latches it into the `data` register and increments the read pointer.
- Count update rule for each cycle:
  - Accepted write only: +1.
  - Pop only: −1.
  - Both in the same cycle: unchanged.
- Feeder FSM has four states:
  - IDLE: if `empty` is low and `ready` is high, pop the head into `data` and go to LOAD. Otherwise stay in IDLE.
  - LOAD: `start` is high for exactly this cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: `start` is low. Go to WAIT_DONE when `ready` is 0.
  - WAIT_DONE: go to IDLE when `ready` is 1.
- `data` is held stable from the pop until the next pop. It never changes while a byte is in flight.
- If `ready` never drops after LOAD, the FSM stays in WAIT_BUSY. This is the consumer's contract: `uart_tx` drops `ready` within 2 cycles of a sampled `start`.
- Reset values while `rstn` is low:
  - Pointers, `count` and `data` are 0.
  - `start` and `overflow` are 0.
  - `empty` is 1 and `full` is 0.
  - FSM is in IDLE.
  - Buffer contents are not reset.
- Reset asserted mid-transmission discards all queued bytes. `uart_tx` shares `rstn` and aborts its own frame.

## Timing
- Write to visibility:
  - A byte written at edge N updates `count` and `empty` after edge N.
  - It can be popped at edge N+1 at the earliest.
  - `start` is then high in the cycle after edge N+1.
- Latency from the first `wr` into an empty FIFO with `ready` high to `start` high: 2 cycles.
- Byte-to-byte overhead beyond the frame time:
  - 1 cycle in IDLE to pop.
  - 1 cycle in LOAD.
  - Plus `uart_tx`'s ready-drop latency.
- `full`, `empty` and `count` are registered and reflect the state after the last edge.
- `overflow` is a registered one-cycle pulse, asserted the cycle after the rejected write.
- Back-to-back writes at one per cycle are accepted until `full`, with no bubbles.

## Test plan
- Reset check: hold `rstn` low for 3 cycles with `wr` toggling.
  - Required: `start`=0, `count`=0, `empty`=1, `overflow`=0 throughout.
  - Required: no pop occurs after release.
- Single byte: write 0x41 with the `uart_tx` model's `ready` high.
  - Required: `data`=0x41 and `start` is a one-cycle pulse 2 cycles after `wr`.
  - Required: `count` returns to 0.
  - Required: exactly one frame appears on `tx`.
- Message order: write "HOLA" (0x48 0x4F 0x4C 0x41) on 4 consecutive cycles.
  - Required: `count` peaks at 3 or 4.
  - Required: 4 `start` pulses, each after `ready` has returned high.
  - Required: `tx` decodes as "HOLA" in order.
- Fill and overflow with DEPTH=16 and `ready` held low: write 17 bytes 0x00–0x10.
  - Required: `full`=1 after the 16th write.
  - Required: `overflow` pulses once for 0x10.
  - After `ready` is raised, required output is 0x00–0x0F only.
- Wrap-around and simultaneity:
  - Stream 40 bytes while the consumer is active, so that the pointers wrap twice.
  - Include cycles where a write and a pop coincide; `count` must stay unchanged on those cycles.
  - Required: all 40 bytes are output in order.
- Reset mid-operation: assert `rstn` low with 5 bytes queued during LOAD.
  - Required: `start` goes low immediately and `count`=0.
  - Required: no queued byte is sent after release.
  - A new write of 0x55 transmits normally.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that feeds a uart_tx one byte at a time via data/start/ready.
//   clk      : system clock, rising edge
//   rstn     : asynchronous active-low reset
//   din, wr  : producer write port, one byte per cycle when not full
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : stored bytes, 0..DEPTH
//   overflow : one-cycle pulse the cycle after a write attempted while full
//   data     : byte presented to uart_tx, held from pop until next pop
//   start    : one-cycle request to uart_tx
//   ready    : uart_tx idle and able to accept a byte
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [7:0]    din,
    input  logic          wr,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [7:0]    data,
    output logic          start,
    input  logic          ready
);
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    state_t        state, state_n;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          push, pop;
    assign full  = count == CNT_FULL;
    assign empty = count == '0;
    // A pop in the same cycle never frees room for a write: push looks at the registered full.
    assign push  = wr && !full;
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        start   = 1'b0;
        case (state)
            IDLE:      if (!empty && ready) begin
                           pop     = 1'b1;
                           state_n = LOAD;
                       end
            LOAD:      begin
                           start   = 1'b1;
                           state_n = WAIT_BUSY;
                       end
            WAIT_BUSY: if (!ready) state_n = WAIT_DONE;
            WAIT_DONE: if (ready) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            data     <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            overflow <= wr && full;
            if (push) wp <= wp + PTR_ONE;
            if (pop) begin
                data <= mem[rp];
                rp   <= rp + PTR_ONE;
            end
            count <= (push && !pop) ? count + CNT_ONE :
                     (pop && !push) ? count - CNT_ONE : count;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized bench for uart_tx_fifo against a queue-based reference
// model, with a behavioural uart_tx stand-in driving ready and collecting sent bytes.
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;
    logic       clk = 1'b0, rstn = 1'b1, wr = 1'b0, ready = 1'b1;
    logic [7:0] din = '0;
    logic       full, empty, overflow, start;
    logic [4:0] count;
    logic [7:0] data;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .din(din), .wr(wr), .full(full), .empty(empty),
        .count(count), .overflow(overflow), .data(data), .start(start), .ready(ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    byte unsigned q[$], sent[$], rx[$];
    // Reference: a byte is "in flight" from its pop until the consumer has gone busy
    // (ready seen low after the start cycle) and idle again (ready seen high).
    logic       m_free = 1'b1, m_load = 1'b0, m_low = 1'b0, m_start = 1'b0, m_ovf = 1'b0;
    logic [7:0] m_data = '0;
    logic       force_low = 1'b0;
    int         busy = 0, drop_wait = 0, fr_max = 6, ovf_seen = 0, coinc = 0, peak = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic w, input logic [7:0] d);
        logic       acc, pop, r, c_start;
        logic [7:0] c_data;
        wr = w;
        din = d;
        r = ready;
        acc = w && q.size() < DEPTH;
        pop = m_free && q.size() > 0 && r;
        c_start = start;
        c_data = data;
        @(posedge clk);
        #1;
        m_ovf = w && !acc;
        m_start = pop;
        if (pop) begin
            m_data = q.pop_front();
            m_free = 1'b0;
            m_load = 1'b1;
            m_low = 1'b0;
        end else if (!m_free) begin
            if (m_load) m_load = 1'b0;
            else if (!m_low) m_low = !r;
            else if (r) m_free = 1'b1;
        end
        if (acc) begin
            q.push_back(d);
            sent.push_back(d);
        end
        if (acc && pop) coinc++;
        if (force_low) ready = 1'b0;
        else if (ready && c_start) begin
            rx.push_back(c_data);
            busy = $urandom_range(1, fr_max);
            drop_wait = $urandom_range(0, 1);
            if (drop_wait == 0) ready = 1'b0;
        end else if (ready && drop_wait > 0) begin
            drop_wait = 0;
            ready = 1'b0;
        end else if (!ready) begin
            if (busy > 0) busy--;
            if (busy == 0) ready = 1'b1;
        end
        if (overflow) ovf_seen++;
        if (int'(count) > peak) peak = int'(count);
        chk("count", count, q.size());
        chk("empty", empty, q.size() == 0);
        chk("full", full, q.size() == DEPTH);
        chk("overflow", overflow, m_ovf);
        chk("start", start, m_start);
        chk("data", data, m_data);
    endtask

    task automatic apply_reset(input int n);
        rstn = 1'b0;
        #1;
        chk("rst_start_async", start, 0);
        chk("rst_count_async", count, 0);
        for (int i = 0; i < n; i++) begin
            wr = i[0];
            din = 8'hA5;
            @(posedge clk);
            #1;
            chk("rst_start", start, 0);
            chk("rst_count", count, 0);
            chk("rst_empty", empty, 1);
            chk("rst_full", full, 0);
            chk("rst_overflow", overflow, 0);
            chk("rst_data", data, 0);
        end
        wr = 1'b0;
        q.delete();
        {m_load, m_low, m_start, m_ovf} = '0;
        m_free = 1'b1;
        m_data = '0;
        force_low = 1'b0;
        busy = 0;
        drop_wait = 0;
        ready = 1'b1;
        rstn = 1'b1;
    endtask

    task automatic new_test();
        rx.delete();
        sent.delete();
        ovf_seen = 0;
        coinc = 0;
        peak = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() > 0 || !m_free || !ready || drop_wait > 0) && n < 2000) begin
            tick(1'b0, 8'h00);
            n++;
        end
        chk("drain_timeout", n < 2000, 1);
    endtask

    task automatic cmp_list(input string tag, input byte unsigned exp[$]);
        chk({tag, "_len"}, rx.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rx.size(); i++) chk(tag, rx[i], exp[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        byte unsigned e[$];
        string        s;
        int           k, guard;
        #2;
        apply_reset(3);
        repeat (4) tick(1'b0, 8'h00);

        new_test();
        tick(1'b1, 8'h41);
        drain();
        e = {};
        e.push_back(8'h41);
        cmp_list("single", e);

        new_test();
        s = "HOLA";
        for (int i = 0; i < 4; i++) tick(1'b1, s[i]);
        drain();
        chk("hola_peak", peak >= 3 && peak <= 4, 1);
        e = {};
        for (int i = 0; i < 4; i++) e.push_back(s[i]);
        cmp_list("hola", e);

        new_test();
        force_low = 1'b1;
        ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tick(1'b1, 8'(i));
            if (i == 15) chk("full16", full, 1);
        end
        tick(1'b0, 8'h00);
        chk("ovf_once", ovf_seen, 1);
        force_low = 1'b0;
        ready = 1'b1;
        drain();
        e = {};
        for (int i = 0; i < 16; i++) e.push_back(8'(i));
        cmp_list("fill", e);

        new_test();
        fr_max = 3;
        k = 0;
        guard = 0;
        while (k < 40 && guard < 5000) begin
            if ($urandom_range(0, 3) == 0 && q.size() < 12) begin
                tick(1'b1, 8'($urandom));
                k++;
            end else tick(1'b0, 8'h00);
            guard++;
        end
        chk("wrap_written", k, 40);
        drain();
        chk("wrap_coincide", coinc > 0, 1);
        e = sent;
        cmp_list("wrap", e);
        fr_max = 6;

        new_test();
        force_low = 1'b1;
        ready = 1'b0;
        for (int i = 0; i < 6; i++) tick(1'b1, 8'(8'h60 + i));
        force_low = 1'b0;
        ready = 1'b1;
        tick(1'b0, 8'h00);
        chk("mid_load_start", start, 1);
        apply_reset(2);
        repeat (10) tick(1'b0, 8'h00);
        chk("mid_no_send", rx.size(), 0);
        tick(1'b1, 8'h55);
        drain();
        e = {};
        e.push_back(8'h55);
        cmp_list("mid_new", e);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
